// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous VRAM between the VGA
// scan-out and a CPU requester. clk runs at twice the pixel rate. Each pixel
// period has two phases. Phase 0 is the VGA read, and it goes to the CPU
// while the display is blanked. Phase 1 always belongs to the CPU. The
// returned pixel and the syncs are re-registered together, so they leave the
// block aligned and one pixel period late.
//
// Ports:
//   clk, rst                  clock (2x pixel) and async active-high reset
//   pix_ce                    timing-generator clock enable (high in phase 1)
//   valid_in, h_addr, v_addr  active flag and pixel coordinates from timing gen
//   hsync_in, vsync_in        syncs from timing gen
//   hsync_out, vsync_out,
//   valid_out, vga_data       syncs, active flag and colour, one pixel late
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ack
//   cpu_ack                   grant strobe (combinational)
//   cpu_rvalid, cpu_rdata     read response, the cycle after a read grant
//   mem_en/we/addr/wdata      VRAM command (combinational)
//   mem_rdata                 VRAM read data, one cycle after a read
module vga_fb_arbiter #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic              pix_ce,
    input  logic              valid_in,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned ADDR_LIMIT = H_RES * V_RES;

    logic              ph;
    logic              rd_oor;
    logic              vga_slot;
    logic              grant;
    logic              cpu_in_range;
    logic [ADDR_W-1:0] pix_addr;

    assign pix_ce = ph;

    // Slot ownership; both are held off while reset is asserted.
    assign vga_slot     = !rst && !ph && valid_in;
    assign grant        = !rst && cpu_req && (ph || !valid_in);
    assign cpu_in_range = cpu_addr < ADDR_W'(ADDR_LIMIT);
    assign cpu_ack      = grant;

    // Linear framebuffer address, computed in ADDR_W width.
    assign pix_addr = ADDR_W'(v_addr) * ADDR_W'(H_RES) + ADDR_W'(h_addr);

    // VRAM command mux.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (vga_slot) begin
            mem_en   = 1'b1;
            mem_addr = pix_addr;
        end else if (grant) begin
            // Out-of-range accesses are acked but never reach the VRAM.
            mem_en   = cpu_in_range;
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            if (cpu_we) begin
                mem_wdata = cpu_wdata;
            end
        end
    end

    // Out-of-range reads return zero instead of stale VRAM output.
    assign cpu_rdata = (cpu_rvalid && !rd_oor) ? mem_rdata : '0;

    // Phase, read-response tracking and pixel/sync re-registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph         <= 1'b0;
            cpu_rvalid <= 1'b0;
            rd_oor     <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            valid_out  <= 1'b0;
            vga_data   <= '0;
        end else begin
            ph         <= ~ph;
            cpu_rvalid <= grant && !cpu_we;
            rd_oor     <= !cpu_in_range;
            // Capture on the edge ending phase 1. mem_rdata still holds the
            // phase-0 pixel read here, even when phase 1 carries a CPU access.
            if (ph) begin
                vga_data  <= valid_in ? mem_rdata : '0;
                hsync_out <= hsync_in;
                vsync_out <= vsync_in;
                valid_out <= valid_in;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a driver issues VGA and CPU traffic
// and pushes the expected responses into queues. A negedge monitor pops them
// as the DUT presents outputs. The reference model is a flat array of
// framebuffer words.
module tb_vga_fb_arbiter;

    localparam int unsigned H_RES  = 640;
    localparam int unsigned V_RES  = 480;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned LIMIT  = H_RES * V_RES;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cpu_t;

    typedef struct packed {
        logic              valid;
        logic              hs;
        logic              vs;
        logic [DATA_W-1:0] data;
    } pix_t;

    typedef struct packed {
        logic              pce;
        logic              ack;
        logic              en;
        logic              we;
        logic              rvalid;
        logic              chk_addr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ctl_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pix_ce;
    logic              valid_in = 1'b0;
    logic [9:0]        h_addr = '0;
    logic [9:0]        v_addr = '0;
    logic              hsync_in = 1'b0;
    logic              vsync_in = 1'b0;
    logic              hsync_out, vsync_out, valid_out;
    logic [DATA_W-1:0] vga_data;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    vga_fb_arbiter #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .valid_in(valid_in), .h_addr(h_addr), .v_addr(v_addr),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .valid_out(valid_out),
        .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // VRAM array driven by the DUT, and an independent reference copy.
    logic [DATA_W-1:0] vram    [LIMIT];
    logic [DATA_W-1:0] ref_mem [LIMIT];

    always @(posedge clk) begin
        if (mem_en && (mem_addr < ADDR_W'(LIMIT))) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= vram[mem_addr];
        end
    end

    // Set on each edge that ends a pix_ce-high cycle.
    logic cap_edge;
    always @(posedge clk or posedge rst) begin
        if (rst) cap_edge <= 1'b0;
        else     cap_edge <= pix_ce;
    end

    ctl_t ctl_q [$];
    pix_t pix_q [$];
    logic [DATA_W-1:0] rd_q [$];

    int   checks = 0;
    int   errors = 0;
    logic end_check = 1'b0;

    // Monitor.
    initial begin
        ctl_t ce, cg;
        pix_t pe, pg;
        logic [DATA_W-1:0] re;
        logic [63:0] rvec;
        forever begin
            @(negedge clk);
            if (rst) begin
                rvec = 64'({pix_ce, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata,
                            hsync_out, vsync_out, valid_out, vga_data,
                            cpu_rvalid, cpu_rdata});
                checks++;
                if (rvec != 64'd0) begin
                    errors++;
                    $display("FAIL reset_outputs got %h exp 0", rvec);
                end
            end else begin
                if (!end_check) begin
                    checks++;
                    if (ctl_q.size() == 0) begin
                        errors++;
                        $display("FAIL ctl_queue got empty exp entry");
                    end else begin
                        ce          = ctl_q.pop_front();
                        cg.pce      = pix_ce;
                        cg.ack      = cpu_ack;
                        cg.en       = mem_en;
                        cg.we       = mem_we;
                        cg.rvalid   = cpu_rvalid;
                        cg.chk_addr = ce.chk_addr;
                        cg.addr     = ce.chk_addr ? mem_addr : '0;
                        cg.wdata    = mem_wdata;
                        if (cg != ce) begin
                            errors++;
                            $display("FAIL ctl t=%0t got pce=%b ack=%b en=%b we=%b rv=%b a=%0d wd=%h exp pce=%b ack=%b en=%b we=%b rv=%b a=%0d wd=%h",
                                     $time, cg.pce, cg.ack, cg.en, cg.we, cg.rvalid, cg.addr, cg.wdata,
                                     ce.pce, ce.ack, ce.en, ce.we, ce.rvalid, ce.addr, ce.wdata);
                        end
                    end
                end
                if (cap_edge) begin
                    checks++;
                    pg = {valid_out, hsync_out, vsync_out, vga_data};
                    if (pix_q.size() == 0) begin
                        errors++;
                        $display("FAIL pixel_queue got empty exp entry");
                    end else begin
                        pe = pix_q.pop_front();
                        if (pg != pe) begin
                            errors++;
                            $display("FAIL pixel t=%0t got v=%b hs=%b vs=%b d=%h exp v=%b hs=%b vs=%b d=%h",
                                     $time, pg.valid, pg.hs, pg.vs, pg.data, pe.valid, pe.hs, pe.vs, pe.data);
                        end
                    end
                end
                checks++;
                if (cpu_rvalid) begin
                    if (rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cpu_read got unexpected rvalid exp none");
                    end else begin
                        re = rd_q.pop_front();
                        if (cpu_rdata != re) begin
                            errors++;
                            $display("FAIL cpu_read t=%0t got %h exp %h", $time, cpu_rdata, re);
                        end
                    end
                end else if (cpu_rdata != '0) begin
                    errors++;
                    $display("FAIL cpu_rdata_idle got %h exp 0", cpu_rdata);
                end
                if (end_check) begin
                    checks++;
                    if ((ctl_q.size() + pix_q.size() + rd_q.size()) != 0) begin
                        errors++;
                        $display("FAIL drain got %0d/%0d/%0d exp 0/0/0",
                                 ctl_q.size(), pix_q.size(), rd_q.size());
                    end
                end
            end
        end
    end

    // Driver state: pixel-period VGA inputs and the CPU requester.
    logic       bph = 1'b0;
    logic       v_valid = 1'b0, v_hs = 1'b0, v_vs = 1'b0;
    logic [9:0] v_h = '0, v_v = '0;
    logic       req_pend = 1'b0, prev_rd = 1'b0;
    cpu_t       cur = '0;
    cpu_t       cpu_q [$];

    task automatic set_vga(input logic va, input int h, input int v,
                           input logic hs, input logic vs);
        v_valid = va; v_h = 10'(h); v_v = 10'(v); v_hs = hs; v_vs = vs;
    endtask

    task automatic push_cpu(input logic we, input int addr, input int wd);
        cpu_q.push_back('{we: we, addr: ADDR_W'(addr), wdata: DATA_W'(wd)});
    endtask

    // One clk cycle, entered and left at posedge+1.
    task automatic step();
        ctl_t c;
        logic g, in_rng;
        int   pa;
        if (!req_pend && cpu_q.size() > 0) begin
            cur = cpu_q.pop_front();
            req_pend = 1'b1;
        end
        valid_in = v_valid; h_addr = v_h; v_addr = v_v;
        hsync_in = v_hs;    vsync_in = v_vs;
        cpu_req = req_pend;
        if (req_pend) begin
            cpu_we = cur.we; cpu_addr = cur.addr; cpu_wdata = cur.wdata;
        end else begin
            cpu_we = 1'($urandom); cpu_addr = ADDR_W'($urandom); cpu_wdata = DATA_W'($urandom);
        end
        pa     = int'(v_v) * int'(H_RES) + int'(v_h);
        g      = req_pend && (bph || !v_valid);
        in_rng = int'(cur.addr) < int'(LIMIT);
        c = '0;
        c.pce    = bph;
        c.ack    = g;
        c.rvalid = prev_rd;
        if (!bph) pix_q.push_back('{valid: v_valid, hs: v_hs, vs: v_vs,
                                    data: v_valid ? ref_mem[pa] : '0});
        if (!bph && v_valid) begin
            c.en = 1'b1; c.chk_addr = 1'b1; c.addr = ADDR_W'(pa);
        end else if (g) begin
            c.en = in_rng; c.we = cur.we; c.chk_addr = 1'b1; c.addr = cur.addr;
            if (cur.we) begin
                c.wdata = cur.wdata;
                if (in_rng) ref_mem[cur.addr] = cur.wdata;
            end else begin
                rd_q.push_back(in_rng ? ref_mem[cur.addr] : '0);
            end
        end
        prev_rd = g && !cur.we;
        if (g) req_pend = 1'b0;
        ctl_q.push_back(c);
        @(posedge clk); #1;
        bph = ~bph;
    endtask

    task automatic align();
        if (bph) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; cpu_req = 1'b1; valid_in = 1'b1;
        ctl_q.delete(); pix_q.delete(); rd_q.delete();
        prev_rd = 1'b0; bph = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_traffic(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            if (!bph) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) set_vga(1'b1, 639, 479, 1'($urandom), 1'($urandom));
                else set_vga($urandom_range(0, 3) != 0, int'($urandom_range(0, 639)),
                             int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            end
            if (!req_pend && cpu_q.size() == 0 && $urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      push_cpu(1'($urandom), int'($urandom_range(LIMIT, 524287)), int'($urandom));
                else if (r == 1) push_cpu(1'($urandom), int'(LIMIT) - 1, int'($urandom));
                else             push_cpu(1'($urandom), int'($urandom_range(0, 2559)), int'($urandom));
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < int'(LIMIT); i++) begin
            vram[i]    = DATA_W'(i * 7 + 3);
            ref_mem[i] = DATA_W'(i * 7 + 3);
        end
        vram[641]    = 12'hABC;
        ref_mem[641] = 12'hABC;

        #1;
        do_reset();

        // Active scan of (1,1) -> address 641.
        set_vga(1'b1, 1, 1, 1'b0, 1'b0);
        step(); step();
        // CPU write during active video: granted only in phase 1.
        set_vga(1'b1, 5, 0, 1'b0, 1'b0);
        push_cpu(1'b1, 100, 'h123);
        step(); step();
        // Read back, then a blanking burst of two reads.
        set_vga(1'b0, 0, 0, 1'b0, 1'b0);
        push_cpu(1'b0, 100, 0);
        step(); step();
        align();
        push_cpu(1'b0, 5, 0);
        push_cpu(1'b0, 6, 0);
        repeat (4) step();
        // Out-of-range write and read, then the last legal word.
        push_cpu(1'b1, int'(LIMIT), 'hFFF);
        push_cpu(1'b0, int'(LIMIT), 0);
        push_cpu(1'b0, int'(LIMIT) - 1, 0);
        repeat (6) step();
        // Sync alignment across pixel boundaries.
        for (int k = 0; k < 4; k++) begin
            set_vga(k[0], 10 + k, 2, k[0], k[1]);
            step(); step();
        end

        rand_traffic(3000);
        // Reset mid-frame; any pending request is re-presented afterwards.
        do_reset();
        rand_traffic(2000);

        // Drain.
        set_vga(1'b0, 0, 0, 1'b0, 1'b0);
        cpu_q.delete();
        repeat (6) step();
        align();
        end_check = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Framebuffer scheduler between the 640x480 VGA timing generator and one single-port synchronous VRAM, which it shares with a CPU-side requester.
- clk runs at 2x pixel rate. The block emits pix_ce, the timing generator's clock enable.
- Each pixel period has two slots. Slot 0 is the VGA read; slot 1 is for the CPU. The CPU may also use slot 0 while the display is blanked.
- Returned pixels and the syncs are re-registered, so colour and sync leave the block aligned, one pixel period late.

Parameters:
H_RES, 640, active pixels per line; used as the address stride.
V_RES, 480, active lines; together with H_RES sets the address limit H_RES*V_RES.
ADDR_W, 19, VRAM word-address width.
DATA_W, 12, pixel width (RGB444).

Ports:
clk  input  1  system clock, 2x pixel clock
rst  input  1  reset
pix_ce  output  1  clock enable for the timing generator; high in phase 1
valid_in  input  1  active-video flag from the timing generator
h_addr  input  10  pixel column from the timing generator
v_addr  input  10  pixel row from the timing generator
hsync_in  input  1  hsync from the timing generator
vsync_in  input  1  vsync from the timing generator
hsync_out  output  1  hsync delayed one pixel
vsync_out  output  1  vsync delayed one pixel
valid_out  output  1  valid delayed one pixel
vga_data  output  DATA_W  pixel colour aligned with the *_out signals
cpu_req  input  1  CPU access request; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_ack  output  1  access granted this cycle
cpu_rvalid  output  1  read data valid
cpu_rdata  output  DATA_W  read data
mem_en  output  1  VRAM access enable
mem_we  output  1  VRAM write enable
mem_addr  output  ADDR_W  VRAM address
mem_wdata  output  DATA_W  VRAM write data
mem_rdata  input  DATA_W  VRAM read data; valid the cycle after a read with mem_en=1

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - ph=0.
  - hsync_out, vsync_out, valid_out, vga_data, cpu_rvalid are 0.
  - cpu_ack and mem_en are 0 while rst is high.
  - Any in-flight CPU access is dropped; the requester re-presents it.
- Phase: ph toggles every clk. pix_ce = (ph==1). The timing generator advances on the edge that ends phase 1, so its outputs are stable across each phase-0/phase-1 pair.
- Phase 0, valid_in=1 (VGA slot):
  - mem_en=1, mem_we=0.
  - mem_addr = v_addr*H_RES + h_addr, truncated to ADDR_W.
  - CPU is not granted.
- Phase 0, valid_in=0 (blanking): the slot goes to the CPU if cpu_req=1; otherwise mem_en=0.
- Phase 1: the slot goes to the CPU if cpu_req=1; otherwise mem_en=0.
- CPU grant cycle:
  - cpu_ack=1, combinational in that cycle.
  - mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - mem_en = (cpu_addr < H_RES*V_RES).
  - cpu_ack is at most one cycle per request. A new request may be presented the cycle after ack.
- CPU read response:
  - cpu_rvalid=1 exactly the cycle after a read grant.
  - cpu_rdata = mem_rdata, or 0 if the granted address was out of range.
  - cpu_rdata = 0 whenever cpu_rvalid=0.
- Out-of-range access: write is acked but no VRAM write occurs; read is acked and returns 0.
- Pixel capture on the edge ending phase 1:
  - vga_data <= valid_in ? mem_rdata : 0.
  - hsync_out <= hsync_in, vsync_out <= vsync_in, valid_out <= valid_in.
- Outputs change only on that edge, one pixel period after the timing generator presented the pixel.
- Slot independence: a CPU grant in phase 1 must not disturb the VGA data already returning that cycle.
- Back-to-back CPU grants in blanking (phase 0 then phase 1) are legal; cpu_rvalid pulses on consecutive cycles.
- mem_* outputs are combinational from ph, the inputs and registered state. mem_wdata = 0 when mem_we=0.
- Max address 479*640+639 = 307199 fits 19 bits. The multiply is computed in ADDR_W width.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst with cpu_req high.
  - Required: all outputs 0 and ph=0.
  - After release, first pix_ce occurs on the 2nd clk.
- Active scan:
  - Stimulus: preload VRAM[641]=12'hABC; drive valid_in=1, h_addr=1, v_addr=1.
  - Required: mem_addr=641 in phase 0; vga_data=12'hABC at the next pix_ce edge.
- CPU write during active video:
  - Stimulus: cpu_req=1, cpu_we=1, addr 100, data 12'h123, raised in phase 0.
  - Required: ack only in the following phase 1; VRAM[100]=12'h123.
  - Required: the VGA pixel for that period is unchanged.
- Blanking burst:
  - Stimulus: valid_in=0; CPU issues reads to 5 then 6.
  - Required: acks in consecutive cycles; cpu_rvalid on the next two cycles with the stored values.
  - Required: vga_data=0.
- Out-of-range access:
  - Stimulus: write 12'hFFF to addr 307200, then read it.
  - Required: both acked with mem_en=0; read returns 0; VRAM[307199] unchanged.
- Sync alignment:
  - Stimulus: toggle hsync_in/vsync_in at a pix_ce boundary.
  - Required: hsync_out/vsync_out follow exactly 2 clk later, in step with vga_data.
